// File: rtl/bluejay_frame_sched.sv
// Two-pass (normal, then inverted for DC balance) line scheduler for one buffered source frame.
// Define BLUEJAY_SCHED_WDT_EN to build in the LINE_WAIT watchdog that drives the sticky error_o.
module bluejay_frame_sched #(
    parameter int LINES_PER_FRAME = 1280,
    parameter int LINE_GAP_CYCLES = 16,
    parameter int WDT_CYCLES      = 65535
) (
    input  logic        clk_i,
    input  logic        reset_i,
    input  logic        enable_i,
    input  logic        frame_avail_i,
    input  logic        fifo_empty_i,
    input  logic        line_done_i,
    output logic        new_frame_o,
    output logic        next_line_rdy_o,
    output logic        invert_o,
    output logic        frame_ack_o,
    output logic        busy_o,
    output logic [10:0] line_count_o,
    output logic [15:0] frame_count_o,
    output logic        error_o
);

    typedef enum logic [2:0] {
        IDLE,
        PASS_START,
        LINE_REQ,
        LINE_WAIT,
        LINE_GAP,
        PASS_END
    } state_t;

    localparam logic [10:0] LAST_LINE = 11'(LINES_PER_FRAME - 1);
    localparam logic [7:0]  LAST_GAP  = 8'(LINE_GAP_CYCLES - 1);

    state_t      state;
    state_t      state_next;
    logic [7:0]  gap_cnt;
    logic [7:0]  gap_cnt_next;
    logic [10:0] line_count_next;
    logic [15:0] frame_count_next;
    logic        new_frame_next;
    logic        next_line_rdy_next;
    logic        frame_ack_next;
    logic        invert_next;
    logic        wdt_expired;

`ifdef BLUEJAY_SCHED_WDT_EN
    localparam int              WDT_W    = $clog2(WDT_CYCLES + 1);
    localparam logic [WDT_W-1:0] WDT_LAST = WDT_W'(WDT_CYCLES - 1);

    logic [WDT_W-1:0] wdt_cnt;
    logic             error_q;

    // The counter sits at zero outside LINE_WAIT, so it starts fresh on every entry.
    assign wdt_expired = (state == LINE_WAIT) && !line_done_i && (wdt_cnt == WDT_LAST);

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            wdt_cnt <= '0;
            error_q <= 1'b0;
        end else begin
            if (state != LINE_WAIT) begin
                wdt_cnt <= '0;
            end else begin
                wdt_cnt <= wdt_cnt + WDT_W'(1);
            end
            if (wdt_expired) begin
                error_q <= 1'b1;
            end
        end
    end

    assign error_o = error_q;
`else
    localparam int unused_wdt_cycles = WDT_CYCLES;

    assign wdt_expired = 1'b0;
    assign error_o     = 1'b0;
`endif

    always_comb begin
        state_next         = state;
        gap_cnt_next       = gap_cnt;
        line_count_next    = line_count_o;
        frame_count_next   = frame_count_o;
        invert_next        = invert_o;
        new_frame_next     = 1'b0;
        next_line_rdy_next = 1'b0;
        frame_ack_next     = 1'b0;

        unique case (state)
            IDLE: begin
                if (enable_i && frame_avail_i) begin
                    state_next  = PASS_START;
                    invert_next = 1'b0;
                end
            end
            PASS_START: begin
                state_next = LINE_REQ;
            end
            LINE_REQ: begin
                if (!fifo_empty_i) begin
                    state_next         = LINE_WAIT;
                    next_line_rdy_next = 1'b1;
                end
            end
            LINE_WAIT: begin
                if (line_done_i) begin
                    if (line_count_o == LAST_LINE) begin
                        // Ack and count land in PASS_END so they never share a cycle with new_frame_o.
                        state_next = PASS_END;
                        if (invert_o) begin
                            frame_ack_next   = 1'b1;
                            frame_count_next = frame_count_o + 16'd1;
                        end
                    end else begin
                        state_next      = LINE_GAP;
                        line_count_next = line_count_o + 11'd1;
                        gap_cnt_next    = '0;
                    end
                end else if (wdt_expired) begin
                    state_next  = IDLE;
                    invert_next = 1'b0;
                end
            end
            LINE_GAP: begin
                if (gap_cnt == LAST_GAP) begin
                    state_next = LINE_REQ;
                end else begin
                    gap_cnt_next = gap_cnt + 8'd1;
                end
            end
            PASS_END: begin
                if (!invert_o) begin
                    invert_next = 1'b1;
                    state_next  = PASS_START;
                end else begin
                    invert_next = 1'b0;
                    state_next  = (enable_i && frame_avail_i) ? PASS_START : IDLE;
                end
            end
            default: begin
                state_next = IDLE;
            end
        endcase

        if (state_next == PASS_START) begin
            new_frame_next  = 1'b1;
            line_count_next = '0;
        end
    end

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            state           <= IDLE;
            gap_cnt         <= '0;
            new_frame_o     <= 1'b0;
            next_line_rdy_o <= 1'b0;
            invert_o        <= 1'b0;
            frame_ack_o     <= 1'b0;
            busy_o          <= 1'b0;
            line_count_o    <= '0;
            frame_count_o   <= '0;
        end else begin
            state           <= state_next;
            gap_cnt         <= gap_cnt_next;
            new_frame_o     <= new_frame_next;
            next_line_rdy_o <= next_line_rdy_next;
            invert_o        <= invert_next;
            frame_ack_o     <= frame_ack_next;
            busy_o          <= (state_next != IDLE);
            line_count_o    <= line_count_next;
            frame_count_o   <= frame_count_next;
        end
    end

endmodule

// File: tb/tb_bluejay_frame_sched.sv
// Directed bench for bluejay_frame_sched: a cycle vector table for start-up, stall and
// ignored-input behaviour, then hand-written multi-cycle frame, reset, watchdog and wrap sequences.
`timescale 1ns/1ps
module tb_bluejay_frame_sched;

    localparam int LPF = 4;
    localparam int GAP = 2;
    localparam int WDT = 20;

    localparam int EV_NF      = 0;
    localparam int EV_RDY     = 1;
    localparam int EV_ACK     = 2;
    localparam int EV_RDY_INV = 3;
    localparam int EV_LC1     = 4;

    logic        clk_i = 1'b0;
    logic        reset_i;
    logic        enable_i;
    logic        frame_avail_i;
    logic        fifo_empty_i;
    logic        line_done_i;
    logic        ld_manual;
    logic        ld_auto;
    logic        auto_done;
    logic        new_frame_o;
    logic        next_line_rdy_o;
    logic        invert_o;
    logic        frame_ack_o;
    logic        busy_o;
    logic [10:0] line_count_o;
    logic [15:0] frame_count_o;
    logic        error_o;

    int checks = 0;
    int errors = 0;

    int nf_cnt      = 0;
    int rdy_cnt     = 0;
    int rdy_inv_cnt = 0;
    int ack_cnt     = 0;
    int overlap_cnt = 0;

    // {rst, en, av, fe, ld} applied for one edge; {nf, rdy, inv, ack, busy} plus line count expected after it.
    typedef struct packed {
        logic [4:0]  stim;
        logic [4:0]  exp_flags;
        logic [10:0] exp_lc;
    } vec_t;

    vec_t vecs [15];

    assign line_done_i = ld_manual | ld_auto;

    always #5 clk_i = ~clk_i;

    bluejay_frame_sched #(
        .LINES_PER_FRAME (LPF),
        .LINE_GAP_CYCLES (GAP),
        .WDT_CYCLES      (WDT)
    ) dut (
        .clk_i           (clk_i),
        .reset_i         (reset_i),
        .enable_i        (enable_i),
        .frame_avail_i   (frame_avail_i),
        .fifo_empty_i    (fifo_empty_i),
        .line_done_i     (line_done_i),
        .new_frame_o     (new_frame_o),
        .next_line_rdy_o (next_line_rdy_o),
        .invert_o        (invert_o),
        .frame_ack_o     (frame_ack_o),
        .busy_o          (busy_o),
        .line_count_o    (line_count_o),
        .frame_count_o   (frame_count_o),
        .error_o         (error_o)
    );

    always @(negedge clk_i) begin
        if (new_frame_o) nf_cnt = nf_cnt + 1;
        if (next_line_rdy_o) rdy_cnt = rdy_cnt + 1;
        if (next_line_rdy_o && invert_o) rdy_inv_cnt = rdy_inv_cnt + 1;
        if (frame_ack_o) ack_cnt = ack_cnt + 1;
        if ((int'(new_frame_o) + int'(next_line_rdy_o) + int'(frame_ack_o)) > 1) overlap_cnt = overlap_cnt + 1;
    end

    // Datapath model: finishes each requested line five cycles after the request.
    initial begin
        ld_auto = 1'b0;
        forever begin
            @(negedge clk_i);
            if (auto_done && next_line_rdy_o) begin
                repeat (5) @(negedge clk_i);
                if (auto_done) begin
                    ld_auto = 1'b1;
                    @(negedge clk_i);
                    ld_auto = 1'b0;
                end
            end
        end
    end

    initial begin
        #1000000;
        $display("[TB] FAIL global_timeout: simulation still running at %0t, required to finish earlier", $time);
        $fatal(1, "[TB] global timeout");
    end

    function automatic vec_t mkVec(input logic [4:0] stim, input logic [4:0] flags, input logic [10:0] lc);
        vec_t v;
        v.stim      = stim;
        v.exp_flags = flags;
        v.exp_lc    = lc;
        return v;
    endfunction

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        checks = checks + 1;
        if (actual !== expected) begin
            errors = errors + 1;
            $display("[TB] FAIL %s: got %0h, expected %0h", name, actual, expected);
        end
    endtask

    task automatic applyStimulus(input logic [4:0] stim);
        reset_i       = stim[4];
        enable_i      = stim[3];
        frame_avail_i = stim[2];
        fifo_empty_i  = stim[1];
        ld_manual     = stim[0];
        @(posedge clk_i);
        #1;
    endtask

    task automatic stepCycles(input int n);
        repeat (n) begin
            @(posedge clk_i);
            #1;
        end
    endtask

    task automatic resetDut();
        auto_done     = 1'b0;
        ld_manual     = 1'b0;
        enable_i      = 1'b0;
        frame_avail_i = 1'b0;
        fifo_empty_i  = 1'b1;
        reset_i       = 1'b1;
        stepCycles(2);
        reset_i = 1'b0;
        stepCycles(8);
    endtask

    task automatic waitEvent(input string name, input int which, input int budget);
        bit seen;
        seen = 1'b0;
        for (int i = 0; i < budget; i++) begin
            @(posedge clk_i);
            #1;
            case (which)
                EV_NF:      seen = new_frame_o;
                EV_RDY:     seen = next_line_rdy_o;
                EV_ACK:     seen = frame_ack_o;
                EV_RDY_INV: seen = next_line_rdy_o & invert_o;
                default:    seen = (line_count_o == 11'd1);
            endcase
            if (seen) break;
        end
        checkOutput(name, 32'(seen), 32'd1);
    endtask

    initial begin
        int b_nf;
        int b_rdy;
        int b_inv;
        int b_ack;

        auto_done     = 1'b0;
        ld_manual     = 1'b0;
        reset_i       = 1'b0;
        enable_i      = 1'b0;
        frame_avail_i = 1'b0;
        fifo_empty_i  = 1'b1;

        vecs[0]  = mkVec(5'b10010, 5'b00000, 11'd0);
        vecs[1]  = mkVec(5'b00110, 5'b00000, 11'd0);
        vecs[2]  = mkVec(5'b01010, 5'b00000, 11'd0);
        vecs[3]  = mkVec(5'b01110, 5'b10001, 11'd0);
        vecs[4]  = mkVec(5'b01010, 5'b00001, 11'd0);
        vecs[5]  = mkVec(5'b01010, 5'b00001, 11'd0);
        vecs[6]  = mkVec(5'b01011, 5'b00001, 11'd0);
        vecs[7]  = mkVec(5'b01000, 5'b01001, 11'd0);
        vecs[8]  = mkVec(5'b01000, 5'b00001, 11'd0);
        vecs[9]  = mkVec(5'b01001, 5'b00001, 11'd1);
        vecs[10] = mkVec(5'b01001, 5'b00001, 11'd1);
        vecs[11] = mkVec(5'b01010, 5'b00001, 11'd1);
        vecs[12] = mkVec(5'b01000, 5'b01001, 11'd1);
        vecs[13] = mkVec(5'b11101, 5'b00000, 11'd0);
        vecs[14] = mkVec(5'b00000, 5'b00000, 11'd0);

        stepCycles(1);
        for (int i = 0; i < 15; i++) begin
            applyStimulus(vecs[i].stim);
            checkOutput($sformatf("vec%0d new_frame", i), 32'(new_frame_o), 32'(vecs[i].exp_flags[4]));
            checkOutput($sformatf("vec%0d next_line_rdy", i), 32'(next_line_rdy_o), 32'(vecs[i].exp_flags[3]));
            checkOutput($sformatf("vec%0d invert", i), 32'(invert_o), 32'(vecs[i].exp_flags[2]));
            checkOutput($sformatf("vec%0d frame_ack", i), 32'(frame_ack_o), 32'(vecs[i].exp_flags[1]));
            checkOutput($sformatf("vec%0d busy", i), 32'(busy_o), 32'(vecs[i].exp_flags[0]));
            checkOutput($sformatf("vec%0d line_count", i), 32'(line_count_o), 32'(vecs[i].exp_lc));
            checkOutput($sformatf("vec%0d frame_count", i), 32'(frame_count_o), 32'd0);
            checkOutput($sformatf("vec%0d error", i), 32'(error_o), 32'd0);
        end
        ld_manual = 1'b0;

        // Full frame: two passes of four lines, FIFO never empty.
        resetDut();
        fifo_empty_i = 1'b0;
        auto_done    = 1'b1;
        b_nf  = nf_cnt;
        b_rdy = rdy_cnt;
        b_inv = rdy_inv_cnt;
        b_ack = ack_cnt;
        enable_i      = 1'b1;
        frame_avail_i = 1'b1;
        stepCycles(1);
        checkOutput("frame latency new_frame", 32'(new_frame_o), 32'd1);
        frame_avail_i = 1'b0;
        stepCycles(1);
        checkOutput("frame latency no early rdy", 32'(next_line_rdy_o), 32'd0);
        stepCycles(1);
        checkOutput("frame first rdy", 32'(next_line_rdy_o), 32'd1);
        waitEvent("frame ack seen", EV_ACK, 400);
        checkOutput("frame count at ack", 32'(frame_count_o), 32'd1);
        checkOutput("frame line_count at ack", 32'(line_count_o), 32'(LPF - 1));
        checkOutput("frame invert at ack", 32'(invert_o), 32'd1);
        stepCycles(3);
        checkOutput("frame busy after", 32'(busy_o), 32'd0);
        checkOutput("frame invert after", 32'(invert_o), 32'd0);
        checkOutput("frame new_frame pulses", 32'(nf_cnt - b_nf), 32'd2);
        checkOutput("frame rdy pulses", 32'(rdy_cnt - b_rdy), 32'(2 * LPF));
        checkOutput("frame inverted rdy pulses", 32'(rdy_inv_cnt - b_inv), 32'(LPF));
        checkOutput("frame ack pulses", 32'(ack_cnt - b_ack), 32'd1);
        checkOutput("pulse overlap", 32'(overlap_cnt), 32'd0);

        // FIFO underrun stall in LINE_REQ.
        resetDut();
        enable_i      = 1'b1;
        frame_avail_i = 1'b1;
        fifo_empty_i  = 1'b1;
        stepCycles(1);
        frame_avail_i = 1'b0;
        stepCycles(1);
        b_rdy = rdy_cnt;
        stepCycles(10);
        checkOutput("stall rdy pulses", 32'(rdy_cnt - b_rdy), 32'd0);
        checkOutput("stall busy", 32'(busy_o), 32'd1);
        fifo_empty_i = 1'b0;
        stepCycles(1);
        checkOutput("stall release rdy", 32'(next_line_rdy_o), 32'd1);
        stepCycles(1);
        checkOutput("stall single rdy", 32'(next_line_rdy_o), 32'd0);

        // Enable dropped after the first line: frame still completes, no restart.
        resetDut();
        fifo_empty_i  = 1'b0;
        auto_done     = 1'b1;
        b_nf  = nf_cnt;
        b_ack = ack_cnt;
        enable_i      = 1'b1;
        frame_avail_i = 1'b1;
        waitEvent("endrop start", EV_NF, 5);
        waitEvent("endrop first line done", EV_LC1, 100);
        enable_i = 1'b0;
        waitEvent("endrop ack seen", EV_ACK, 400);
        stepCycles(10);
        checkOutput("endrop busy", 32'(busy_o), 32'd0);
        checkOutput("endrop frame_count", 32'(frame_count_o), 32'd1);
        checkOutput("endrop new_frame pulses", 32'(nf_cnt - b_nf), 32'd2);
        checkOutput("endrop ack pulses", 32'(ack_cnt - b_ack), 32'd1);

        // Reset during LINE_WAIT of the inverted pass, with line_done asserted alongside.
        resetDut();
        fifo_empty_i  = 1'b0;
        auto_done     = 1'b1;
        b_ack = ack_cnt;
        enable_i      = 1'b1;
        frame_avail_i = 1'b1;
        waitEvent("rst start", EV_NF, 5);
        frame_avail_i = 1'b0;
        enable_i      = 1'b0;
        waitEvent("rst inverted rdy", EV_RDY_INV, 300);
        auto_done = 1'b0;
        reset_i   = 1'b1;
        ld_manual = 1'b1;
        stepCycles(1);
        checkOutput("rst new_frame", 32'(new_frame_o), 32'd0);
        checkOutput("rst rdy", 32'(next_line_rdy_o), 32'd0);
        checkOutput("rst invert", 32'(invert_o), 32'd0);
        checkOutput("rst ack", 32'(frame_ack_o), 32'd0);
        checkOutput("rst busy", 32'(busy_o), 32'd0);
        checkOutput("rst line_count", 32'(line_count_o), 32'd0);
        checkOutput("rst frame_count", 32'(frame_count_o), 32'd0);
        checkOutput("rst error", 32'(error_o), 32'd0);
        reset_i   = 1'b0;
        ld_manual = 1'b0;
        stepCycles(15);
        checkOutput("rst no ack", 32'(ack_cnt - b_ack), 32'd0);
        checkOutput("rst idle busy", 32'(busy_o), 32'd0);

`ifdef BLUEJAY_SCHED_WDT_EN
        // Watchdog: withhold line_done for WDT cycles, then a later frame still runs.
        resetDut();
        fifo_empty_i  = 1'b0;
        b_ack = ack_cnt;
        enable_i      = 1'b1;
        frame_avail_i = 1'b1;
        waitEvent("wdt start", EV_NF, 5);
        frame_avail_i = 1'b0;
        waitEvent("wdt rdy", EV_RDY, 10);
        stepCycles(WDT - 1);
        checkOutput("wdt error before limit", 32'(error_o), 32'd0);
        checkOutput("wdt busy before limit", 32'(busy_o), 32'd1);
        stepCycles(1);
        checkOutput("wdt error at limit", 32'(error_o), 32'd1);
        checkOutput("wdt idle", 32'(busy_o), 32'd0);
        checkOutput("wdt invert cleared", 32'(invert_o), 32'd0);
        checkOutput("wdt no ack", 32'(ack_cnt - b_ack), 32'd0);
        auto_done     = 1'b1;
        frame_avail_i = 1'b1;
        waitEvent("wdt later start", EV_NF, 5);
        frame_avail_i = 1'b0;
        waitEvent("wdt later ack", EV_ACK, 400);
        checkOutput("wdt later frame_count", 32'(frame_count_o), 32'd1);
        checkOutput("wdt error sticky", 32'(error_o), 32'd1);
`else
        // No watchdog: a withheld line_done leaves the scheduler waiting with no error.
        resetDut();
        fifo_empty_i  = 1'b0;
        b_ack = ack_cnt;
        enable_i      = 1'b1;
        frame_avail_i = 1'b1;
        waitEvent("nowdt start", EV_NF, 5);
        frame_avail_i = 1'b0;
        waitEvent("nowdt rdy", EV_RDY, 10);
        stepCycles(3 * WDT);
        checkOutput("nowdt still busy", 32'(busy_o), 32'd1);
        checkOutput("nowdt error", 32'(error_o), 32'd0);
        checkOutput("nowdt no ack", 32'(ack_cnt - b_ack), 32'd0);
`endif

        // Frame counter wrap from 65535 to 0.
        resetDut();
        force dut.frame_count_o = 16'hFFFF;
        stepCycles(1);
        release dut.frame_count_o;
        stepCycles(1);
        checkOutput("wrap preload", 32'(frame_count_o), 32'h0000FFFF);
        fifo_empty_i  = 1'b0;
        auto_done     = 1'b1;
        enable_i      = 1'b1;
        frame_avail_i = 1'b1;
        waitEvent("wrap start", EV_NF, 5);
        frame_avail_i = 1'b0;
        waitEvent("wrap ack", EV_ACK, 400);
        checkOutput("wrap frame_count", 32'(frame_count_o), 32'd0);
        checkOutput("wrap pulse overlap", 32'(overlap_cnt), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
